// File: rtl/video_timing_pkg.sv
// Shared 720p60 raster constants and counter widths for the pixel pipeline.
// Consumer stages import these instead of hard-coding the active-region limits.
package video_timing_pkg;

    localparam int unsigned H_ACTIVE = 1280;
    localparam int unsigned H_FP     = 110;
    localparam int unsigned H_SYNC   = 40;
    localparam int unsigned H_BP     = 220;
    localparam int unsigned V_ACTIVE = 720;
    localparam int unsigned V_FP     = 5;
    localparam int unsigned V_SYNC   = 5;
    localparam int unsigned V_BP     = 20;

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam int unsigned HCOUNT_W = 11;
    localparam int unsigned VCOUNT_W = 10;

endpackage

// File: rtl/video_sig_gen_wrap_counter.sv
// Counter 0..MAX that wraps to 0; resets to MAX so the first increment lands on 0.
// Exposes the next count so the owner can register decodes in step with the count.
module wrap_counter #(
    parameter int unsigned MAX   = 1,
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o,
    output logic [WIDTH-1:0] next_o,
    output logic             wrap_o
);

    localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

    logic [WIDTH-1:0] count_q;
    logic [WIDTH-1:0] count_d;

    always_comb begin
        wrap_o  = inc_i && (count_q == MAX_V);
        count_d = count_q;
        if (inc_i) begin
            count_d = wrap_o ? '0 : count_q + WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_q <= MAX_V;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    assign next_o  = count_d;

endmodule

// File: rtl/video_sig_gen.sv
// Free-running raster timing generator: h/v counts, syncs, active window,
// line/frame strobes and a wrapping frame counter, all registered together.
module video_sig_gen #(
    parameter int unsigned H_ACTIVE = video_timing_pkg::H_ACTIVE,
    parameter int unsigned H_FP     = video_timing_pkg::H_FP,
    parameter int unsigned H_SYNC   = video_timing_pkg::H_SYNC,
    parameter int unsigned H_BP     = video_timing_pkg::H_BP,
    parameter int unsigned V_ACTIVE = video_timing_pkg::V_ACTIVE,
    parameter int unsigned V_FP     = video_timing_pkg::V_FP,
    parameter int unsigned V_SYNC   = video_timing_pkg::V_SYNC,
    parameter int unsigned V_BP     = video_timing_pkg::V_BP,
    parameter int unsigned FC_WIDTH = 6
) (
    input  logic                                  clk,
    input  logic                                  rst_n,
    input  logic                                  en,
    output logic [video_timing_pkg::HCOUNT_W-1:0] h_count_out,
    output logic [video_timing_pkg::VCOUNT_W-1:0] v_count_out,
    output logic                                  hsync_out,
    output logic                                  vsync_out,
    output logic                                  active_draw_out,
    output logic                                  new_line_out,
    output logic                                  new_frame_out,
    output logic [FC_WIDTH-1:0]                   frame_count_out
);

    import video_timing_pkg::HCOUNT_W;
    import video_timing_pkg::VCOUNT_W;

    localparam int unsigned H_TOT = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOT = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [HCOUNT_W-1:0] H_ACT_END = HCOUNT_W'(H_ACTIVE);
    localparam logic [HCOUNT_W-1:0] HS_START  = HCOUNT_W'(H_ACTIVE + H_FP);
    localparam logic [HCOUNT_W-1:0] HS_END    = HCOUNT_W'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VCOUNT_W-1:0] V_ACT_END = VCOUNT_W'(V_ACTIVE);
    localparam logic [VCOUNT_W-1:0] VS_START  = VCOUNT_W'(V_ACTIVE + V_FP);
    localparam logic [VCOUNT_W-1:0] VS_END    = VCOUNT_W'(V_ACTIVE + V_FP + V_SYNC);

    logic [HCOUNT_W-1:0] h_d;
    logic [VCOUNT_W-1:0] v_d;
    logic                h_wrap;
    logic                v_wrap;

    wrap_counter #(.MAX(H_TOT - 1), .WIDTH(HCOUNT_W)) u_h_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (en),
        .count_o (h_count_out),
        .next_o  (h_d),
        .wrap_o  (h_wrap)
    );

    // h_wrap already implies en, so v only moves on the last pixel of a line.
    wrap_counter #(.MAX(V_TOT - 1), .WIDTH(VCOUNT_W)) u_v_cnt (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc_i   (h_wrap),
        .count_o (v_count_out),
        .next_o  (v_d),
        .wrap_o  (v_wrap)
    );

    logic                hsync_q, hsync_d;
    logic                vsync_q, vsync_d;
    logic                active_q, active_d;
    logic                new_line_q, new_line_d;
    logic                new_frame_q, new_frame_d;
    logic [FC_WIDTH-1:0] fc_q, fc_d;

    // Decode the next position so flags land on the same edge as the counts.
    always_comb begin
        hsync_d     = hsync_q;
        vsync_d     = vsync_q;
        active_d    = active_q;
        new_line_d  = 1'b0;
        new_frame_d = 1'b0;
        fc_d        = fc_q;
        if (en) begin
            hsync_d     = (h_d >= HS_START) && (h_d < HS_END);
            vsync_d     = (v_d >= VS_START) && (v_d < VS_END);
            active_d    = (h_d < H_ACT_END) && (v_d < V_ACT_END);
            new_line_d  = h_wrap;
            new_frame_d = h_wrap && v_wrap;
            if (new_frame_d) begin
                fc_d = fc_q + FC_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hsync_q     <= 1'b0;
            vsync_q     <= 1'b0;
            active_q    <= 1'b0;
            new_line_q  <= 1'b0;
            new_frame_q <= 1'b0;
            fc_q        <= '1;
        end else begin
            hsync_q     <= hsync_d;
            vsync_q     <= vsync_d;
            active_q    <= active_d;
            new_line_q  <= new_line_d;
            new_frame_q <= new_frame_d;
            fc_q        <= fc_d;
        end
    end

    assign hsync_out       = hsync_q;
    assign vsync_out       = vsync_q;
    assign active_draw_out = active_q;
    assign new_line_out    = new_line_q;
    assign new_frame_out   = new_frame_q;
    assign frame_count_out = fc_q;

endmodule

// File: tb/tb_video_sig_gen.sv
// Bench for video_sig_gen: a reduced-timing instance for whole-frame and wrap
// behaviour plus a default 720p instance, both checked against a position model.
module tb_video_sig_gen;

    // Reduced timing for the small instance.
    localparam int S_HA = 16, S_HF = 3, S_HS = 4, S_HB = 5;
    localparam int S_VA = 6,  S_VF = 2, S_VS = 2, S_VB = 3;
    localparam int S_N  = (S_HA + S_HF + S_HS + S_HB) * (S_VA + S_VF + S_VS + S_VB);
    localparam int B_HA = 1280, B_HF = 110, B_HS = 40, B_HB = 220;
    localparam int B_VA = 720,  B_VF = 5,   B_VS = 5,  B_VB = 20;
    localparam int B_N  = (B_HA + B_HF + B_HS + B_HB) * (B_VA + B_VF + B_VS + B_VB);

    logic clk = 1'b0;
    logic rst_n;
    logic en;

    logic [10:0] s_h, b_h;
    logic [9:0]  s_v, b_v;
    logic        s_hs, s_vs, s_ad, s_nl, s_nf;
    logic        b_hs, b_vs, b_ad, b_nl, b_nf;
    logic [5:0]  s_fc, b_fc;

    int checks = 0;
    int errors = 0;

    // Model: linear raster position, frames started, and whether the last edge advanced.
    int pos_s, pos_b, fc_s, fc_b;
    bit strb;

    always #5 clk = ~clk;

    video_sig_gen #(
        .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
        .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB),
        .FC_WIDTH(6)
    ) u_small (
        .clk(clk), .rst_n(rst_n), .en(en),
        .h_count_out(s_h), .v_count_out(s_v),
        .hsync_out(s_hs), .vsync_out(s_vs), .active_draw_out(s_ad),
        .new_line_out(s_nl), .new_frame_out(s_nf), .frame_count_out(s_fc)
    );

    video_sig_gen u_big (
        .clk(clk), .rst_n(rst_n), .en(en),
        .h_count_out(b_h), .v_count_out(b_v),
        .hsync_out(b_hs), .vsync_out(b_vs), .active_draw_out(b_ad),
        .new_line_out(b_nl), .new_frame_out(b_nf), .frame_count_out(b_fc)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d t=%0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_dut(input string nm,
                             input int ha, input int hf, input int hs, input int hb,
                             input int va, input int vf, input int vs, input int vb,
                             input int pos, input int fc, input bit st,
                             input logic [10:0] h_o, input logic [9:0] v_o,
                             input logic hs_o, input logic vs_o, input logic ad_o,
                             input logic nl_o, input logic nf_o, input logic [5:0] fc_o);
        int ht, h, v;
        ht = ha + hf + hs + hb;
        h  = pos % ht;
        v  = pos / ht;
        chk({nm, "_h"},     32'(h_o), 32'(h));
        chk({nm, "_v"},     32'(v_o), 32'(v));
        chk({nm, "_hsync"}, 32'(hs_o), 32'((h >= ha + hf) && (h < ha + hf + hs)));
        chk({nm, "_vsync"}, 32'(vs_o), 32'((v >= va + vf) && (v < va + vf + vs)));
        chk({nm, "_active"}, 32'(ad_o), 32'((h < ha) && (v < va)));
        chk({nm, "_newline"}, 32'(nl_o), 32'(st && (h == 0)));
        chk({nm, "_newframe"}, 32'(nf_o), 32'(st && (pos == 0)));
        chk({nm, "_fcount"}, 32'(fc_o), 32'(fc));
    endtask

    task automatic check_all();
        check_dut("small", S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB,
                  pos_s, fc_s, strb, s_h, s_v, s_hs, s_vs, s_ad, s_nl, s_nf, s_fc);
        check_dut("big", B_HA, B_HF, B_HS, B_HB, B_VA, B_VF, B_VS, B_VB,
                  pos_b, fc_b, strb, b_h, b_v, b_hs, b_vs, b_ad, b_nl, b_nf, b_fc);
    endtask

    task automatic model_reset();
        pos_s = S_N - 1;
        pos_b = B_N - 1;
        fc_s  = 63;
        fc_b  = 63;
        strb  = 1'b0;
    endtask

    // One clock: advance the model per the sampled en, then check #1 after the edge.
    task automatic tick();
        @(posedge clk);
        if (rst_n) begin
            if (en) begin
                pos_s = (pos_s + 1) % S_N;
                pos_b = (pos_b + 1) % B_N;
                if (pos_s == 0) fc_s = (fc_s + 1) % 64;
                if (pos_b == 0) fc_b = (fc_b + 1) % 64;
                strb = 1'b1;
            end else begin
                strb = 1'b0;
            end
        end
        #1;
        check_all();
    endtask

    task automatic run(input int n, input logic en_v);
        en = en_v;
        for (int i = 0; i < n; i++) tick();
    endtask

    initial begin
        en    = 1'b0;
        rst_n = 1'b1;
        model_reset();
        #1 rst_n = 1'b0;
        #1 check_all();
        run(3, 1'b1);

        rst_n = 1'b1;
        run(2, 1'b0);

        // First enabled edge lands on (0,0) with both strobes and frame 0.
        run(1, 1'b1);
        chk("first_h", 32'(b_h), 32'd0);
        chk("first_nf", 32'(b_nf), 32'd1);
        chk("first_fc", 32'(s_fc), 32'd0);

        // Hold at h=0, then at big h=500.
        run(7, 1'b0);
        en = 1'b1;
        for (int i = 0; i < 4000 && (pos_b % 1650) != 500; i++) tick();
        chk("reach_h500", 32'(pos_b % 1650), 32'd500);
        run(7, 1'b0);
        run(3500, 1'b1);

        // Randomised enable pattern.
        for (int i = 0; i < 800; i++) begin
            en = ($urandom_range(0, 3) != 0);
            tick();
        end

        // Asynchronous reset in the middle of a cycle, mid-frame.
        run($urandom_range(50, 300), 1'b1);
        #3 rst_n = 1'b0;
        model_reset();
        #1 check_all();
        run(2, 1'b1);
        rst_n = 1'b1;
        run(1, 1'b1);
        chk("restart_nf", 32'(s_nf), 32'd1);
        chk("restart_fc", 32'(s_fc), 32'd0);

        // More than 64 small frames so the frame counter wraps.
        run(65 * S_N + 40, 1'b1);
        chk("fc_wrapped", 32'(fc_s), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
